// File: rtl/ups_dac_spi_tx.sv
// Dual-channel SPI transmitter for an MCP4922-style 12-bit DAC.
// Buffers one word per channel, shifts 16-bit frames MSB first and pulses LDAC once per burst.
module ups_dac_spi_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter logic        BUF_EN  = 1'b0,
    parameter logic        GAIN_1X = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] dac0,
    input  logic        dac0_dv,
    input  logic [11:0] dac1,
    input  logic        dac1_dv,
    output logic        busy,
    output logic        dac0_ovf,
    output logic        dac1_ovf,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_sdi,
    output logic        dac_ldac_n
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_LDAC  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shreg_q, shreg_d;
    logic        chan_q, chan_d;
    logic        chained_q, chained_d;
    logic        pend0_q, pend0_d, pend1_q, pend1_d;
    logic [11:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic        ovf0_q, ovf0_d, ovf1_q, ovf1_d;
    logic        cs_n_q, cs_n_d, sclk_q, sclk_d, sdi_q, sdi_d;
    logic        ldac_n_q, ldac_n_d, busy_q, busy_d;
    logic        take0, take1;

    function automatic logic [15:0] make_frame(input logic ch, input logic [11:0] data);
        return {ch, BUF_EN, GAIN_1X, 1'b1, data};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        chan_d    = chan_q;
        chained_d = chained_q;
        cs_n_d    = 1'b1;
        sclk_d    = 1'b0;
        sdi_d     = 1'b0;
        ldac_n_d  = 1'b1;
        take0     = 1'b0;
        take1     = 1'b0;
        case (state_q)
            S_IDLE: begin
                chained_d = 1'b0;
                if (pend0_q || pend1_q) begin
                    take0   = pend0_q;
                    take1   = !pend0_q;
                    chan_d  = !pend0_q;
                    shreg_d = pend0_q ? make_frame(1'b0, hold0_q) : make_frame(1'b1, hold1_q);
                    state_d = S_SETUP;
                    cnt_d   = DIV_M1;
                    cs_n_d  = 1'b0;
                    sdi_d   = shreg_d[15];
                end
            end
            S_SETUP: begin
                cs_n_d = 1'b0;
                sdi_d  = shreg_q[15];
                if (cnt_q == 8'd0) begin
                    state_d = S_SHIFT;
                    cnt_d   = DIV_M1;
                    bit_d   = 4'd0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SHIFT: begin
                cs_n_d = 1'b0;
                sclk_d = sclk_q;
                sdi_d  = shreg_q[15];
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (sclk_q) begin
                    // Falling SCLK edge: present the next bit so it is stable for the next rise.
                    sclk_d  = 1'b0;
                    cnt_d   = DIV_M1;
                    shreg_d = {shreg_q[14:0], 1'b0};
                    sdi_d   = shreg_q[14];
                end else if (bit_q == 4'd15) begin
                    state_d = S_HOLD;
                    cnt_d   = DIV_M1;
                    cs_n_d  = 1'b1;
                    sdi_d   = 1'b0;
                    sclk_d  = 1'b0;
                end else begin
                    sclk_d = 1'b1;
                    cnt_d  = DIV_M1;
                    bit_d  = bit_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!chained_q && (chan_q ? pend0_q : pend1_q)) begin
                    // Only one chained frame per burst, so a re-pended first channel waits for IDLE.
                    take0     = chan_q;
                    take1     = !chan_q;
                    chan_d    = !chan_q;
                    chained_d = 1'b1;
                    shreg_d   = chan_q ? make_frame(1'b0, hold0_q) : make_frame(1'b1, hold1_q);
                    state_d   = S_SETUP;
                    cnt_d     = DIV_M1;
                    cs_n_d    = 1'b0;
                    sdi_d     = shreg_d[15];
                end else begin
                    state_d  = S_LDAC;
                    cnt_d    = DIV_M1;
                    ldac_n_d = 1'b0;
                end
            end
            S_LDAC: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d    = cnt_q - 8'd1;
                    ldac_n_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                chained_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // A strobe always wins the hold register; overwrite is only flagged if the old word was never taken.
    always_comb begin
        pend0_d = pend0_q;
        hold0_d = hold0_q;
        ovf0_d  = 1'b0;
        pend1_d = pend1_q;
        hold1_d = hold1_q;
        ovf1_d  = 1'b0;
        if (take0) begin
            pend0_d = 1'b0;
        end
        if (take1) begin
            pend1_d = 1'b0;
        end
        if (dac0_dv) begin
            pend0_d = 1'b1;
            hold0_d = dac0;
            ovf0_d  = pend0_q && !take0;
        end
        if (dac1_dv) begin
            pend1_d = 1'b1;
            hold1_d = dac1;
            ovf1_d  = pend1_q && !take1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            bit_q     <= 4'd0;
            shreg_q   <= 16'd0;
            chan_q    <= 1'b0;
            chained_q <= 1'b0;
            pend0_q   <= 1'b0;
            pend1_q   <= 1'b0;
            hold0_q   <= 12'd0;
            hold1_q   <= 12'd0;
            ovf0_q    <= 1'b0;
            ovf1_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
            ldac_n_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            chan_q    <= chan_d;
            chained_q <= chained_d;
            pend0_q   <= pend0_d;
            pend1_q   <= pend1_d;
            hold0_q   <= hold0_d;
            hold1_q   <= hold1_d;
            ovf0_q    <= ovf0_d;
            ovf1_q    <= ovf1_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdi_q     <= sdi_d;
            ldac_n_q  <= ldac_n_d;
            busy_q    <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign dac0_ovf   = ovf0_q;
    assign dac1_ovf   = ovf1_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_sdi    = sdi_q;
    assign dac_ldac_n = ldac_n_q;

endmodule

// File: tb/tb_ups_dac_spi_tx.sv
// Bench for ups_dac_spi_tx: three instances (CLK_DIV 1, 2, 5) share stimulus;
// a pin-level decoder rebuilds frames and timing, which are compared against expected values.
module tb_ups_dac_spi_tx;

    localparam int NI   = 3;
    localparam int MAXF = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] dac0  = 12'd0;
    logic [11:0] dac1  = 12'd0;
    logic        dac0_dv = 1'b0;
    logic        dac1_dv = 1'b0;
    logic [NI-1:0] busy_w, ovf0_w, ovf1_w, cs_w, sclk_w, sdi_w, ldac_w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int div_of[NI] = '{1, 2, 5};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ups_dac_spi_tx #(.CLK_DIV(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .dac0(dac0), .dac0_dv(dac0_dv), .dac1(dac1), .dac1_dv(dac1_dv),
        .busy(busy_w[0]), .dac0_ovf(ovf0_w[0]), .dac1_ovf(ovf1_w[0]), .dac_cs_n(cs_w[0]),
        .dac_sclk(sclk_w[0]), .dac_sdi(sdi_w[0]), .dac_ldac_n(ldac_w[0]));

    ups_dac_spi_tx #(.CLK_DIV(2)) dut_d2 (
        .clk(clk), .rst_n(rst_n), .dac0(dac0), .dac0_dv(dac0_dv), .dac1(dac1), .dac1_dv(dac1_dv),
        .busy(busy_w[1]), .dac0_ovf(ovf0_w[1]), .dac1_ovf(ovf1_w[1]), .dac_cs_n(cs_w[1]),
        .dac_sclk(sclk_w[1]), .dac_sdi(sdi_w[1]), .dac_ldac_n(ldac_w[1]));

    ups_dac_spi_tx #(.CLK_DIV(5)) dut_d5 (
        .clk(clk), .rst_n(rst_n), .dac0(dac0), .dac0_dv(dac0_dv), .dac1(dac1), .dac1_dv(dac1_dv),
        .busy(busy_w[2]), .dac0_ovf(ovf0_w[2]), .dac1_ovf(ovf1_w[2]), .dac_cs_n(cs_w[2]),
        .dac_sclk(sclk_w[2]), .dac_sdi(sdi_w[2]), .dac_ldac_n(ldac_w[2]));

    logic [15:0] frame_log[NI][MAXF];
    int          frame_bits[NI][MAXF];
    int          cs_fall[NI][MAXF];
    int          cs_rise[NI][MAXF];
    int          ldac_fall[NI][MAXF];
    int          ldac_rise[NI][MAXF];
    int          frame_cnt[NI], ldac_cnt[NI], phase_err[NI];
    int          ovf0_cnt[NI], ovf1_cnt[NI], busy_rise[NI], busy_fall[NI];
    int          run_len[NI], nbits[NI];
    logic        run_val[NI];
    logic [15:0] sh[NI];
    logic        prev_cs[NI], prev_sclk[NI], prev_ldac[NI], prev_busy[NI];
    logic        clear_req = 1'b0;

    // Pin decoder: bits captured on SCLK rises inside CS, every SCLK run inside CS must last D cycles.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (clear_req) begin
                frame_cnt[i] = 0; ldac_cnt[i] = 0; phase_err[i] = 0;
                ovf0_cnt[i] = 0; ovf1_cnt[i] = 0; busy_rise[i] = -1; busy_fall[i] = -1;
                run_len[i] = 0; nbits[i] = 0; sh[i] = 16'd0; run_val[i] = 1'b0;
            end else begin
                if (!cs_w[i]) begin
                    if (prev_cs[i]) begin
                        if (frame_cnt[i] < MAXF) cs_fall[i][frame_cnt[i]] = cyc;
                        sh[i] = 16'd0; nbits[i] = 0; run_val[i] = sclk_w[i]; run_len[i] = 1;
                    end else if (sclk_w[i] == run_val[i]) begin
                        run_len[i]++;
                    end else begin
                        if (run_len[i] != div_of[i]) phase_err[i]++;
                        run_val[i] = sclk_w[i]; run_len[i] = 1;
                    end
                    if (sclk_w[i] && !prev_sclk[i]) begin
                        sh[i] = {sh[i][14:0], sdi_w[i]};
                        nbits[i]++;
                    end
                end else if (!prev_cs[i]) begin
                    if (run_len[i] != div_of[i]) phase_err[i]++;
                    if (frame_cnt[i] < MAXF) begin
                        cs_rise[i][frame_cnt[i]] = cyc;
                        frame_log[i][frame_cnt[i]] = sh[i];
                        frame_bits[i][frame_cnt[i]] = nbits[i];
                    end
                    frame_cnt[i]++;
                end
                if (!ldac_w[i] && prev_ldac[i] && ldac_cnt[i] < MAXF) ldac_fall[i][ldac_cnt[i]] = cyc;
                if (ldac_w[i] && !prev_ldac[i]) begin
                    if (ldac_cnt[i] < MAXF) ldac_rise[i][ldac_cnt[i]] = cyc;
                    ldac_cnt[i]++;
                end
                if (busy_w[i] && !prev_busy[i] && busy_rise[i] < 0) busy_rise[i] = cyc;
                if (!busy_w[i] && prev_busy[i] && busy_fall[i] < 0) busy_fall[i] = cyc;
                if (ovf0_w[i]) ovf0_cnt[i]++;
                if (ovf1_w[i]) ovf1_cnt[i]++;
            end
            prev_cs[i]   = cs_w[i];
            prev_sclk[i] = sclk_w[i];
            prev_ldac[i] = ldac_w[i];
            prev_busy[i] = busy_w[i];
        end
    end

    function automatic logic [15:0] exp_frame(input logic ch, input logic [11:0] data);
        return (ch ? 16'h8000 : 16'h0000) + 16'h2000 + 16'h1000 + {4'h0, data};
    endfunction

    task automatic clear_logs();
        clear_req = 1'b1;
        @(negedge clk);
        #1 clear_req = 1'b0;
    endtask

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic a, input logic [11:0] wa, input logic b,
                          input logic [11:0] wb, output int t0);
        @(posedge clk);
        #1;
        dac0 = wa; dac0_dv = a; dac1 = wb; dac1_dv = b;
        t0 = cyc;
        @(posedge clk);
        #1;
        dac0_dv = 1'b0; dac1_dv = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < 3000) begin
            @(negedge clk);
            quiet = (busy_w == '0) ? quiet + 1 : 0;
            n++;
        end
        checks++;
        if (quiet < 8) begin
            failures++;
            $display("[TB] FAIL wait_idle: busy=%b still active after %0d cycles, required idle", busy_w, n);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        next_cycle(3);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({cs_w[i], sclk_w[i], sdi_w[i], ldac_w[i], busy_w[i], ovf0_w[i], ovf1_w[i]} !== 7'b1001000) begin
                failures++;
                $display("[TB] FAIL reset_state inst%0d: got %b required 1001000", i,
                         {cs_w[i], sclk_w[i], sdi_w[i], ldac_w[i], busy_w[i], ovf0_w[i], ovf1_w[i]});
            end
        end
        #1 rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_single_a();
        int t0;
        int d;
        clear_logs();
        strobe(1'b1, 12'hABC, 1'b0, 12'h000, t0);
        wait_idle();
        for (int i = 0; i < NI; i++) begin
            d = div_of[i];
            checks++;
            if (frame_cnt[i] !== 1 || frame_log[i][0] !== 16'h3ABC || frame_bits[i][0] !== 16) begin
                failures++;
                $display("[TB] FAIL single_frame inst%0d: got n=%0d frame=%h bits=%0d required n=1 frame=3abc bits=16",
                         i, frame_cnt[i], frame_log[i][0], frame_bits[i][0]);
            end
            checks++;
            if (cs_fall[i][0] - t0 !== 2 || cs_rise[i][0] - t0 !== 2 + 33 * d || busy_rise[i] - t0 !== 2) begin
                failures++;
                $display("[TB] FAIL single_cs_window inst%0d: got cs %0d..%0d busy_up %0d required 2..%0d busy_up 2",
                         i, cs_fall[i][0] - t0, cs_rise[i][0] - t0, busy_rise[i] - t0, 2 + 33 * d);
            end
            checks++;
            if (ldac_cnt[i] !== 1 || ldac_fall[i][0] - t0 !== 2 + 34 * d || ldac_rise[i][0] - t0 !== 2 + 35 * d
                || busy_fall[i] - t0 !== 2 + 35 * d) begin
                failures++;
                $display("[TB] FAIL single_ldac inst%0d: got n=%0d ldac %0d..%0d busy_down %0d required 1 %0d..%0d %0d",
                         i, ldac_cnt[i], ldac_fall[i][0] - t0, ldac_rise[i][0] - t0, busy_fall[i] - t0,
                         2 + 34 * d, 2 + 35 * d, 2 + 35 * d);
            end
        end
    endtask

    task automatic test_random_frames();
        int t0;
        logic ch;
        logic [11:0] w;
        for (int k = 0; k < 6; k++) begin
            ch = 1'($urandom_range(0, 1));
            w  = 12'($urandom);
            clear_logs();
            strobe(!ch, w, ch, w, t0);
            wait_idle();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (frame_cnt[i] !== 1 || frame_log[i][0] !== exp_frame(ch, w) || ldac_cnt[i] !== 1
                    || phase_err[i] !== 0) begin
                    failures++;
                    $display("[TB] FAIL random_frame inst%0d: got n=%0d frame=%h ldac=%0d perr=%0d required 1 %h 1 0",
                             i, frame_cnt[i], frame_log[i][0], ldac_cnt[i], phase_err[i], exp_frame(ch, w));
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        int d;
        clear_logs();
        strobe(1'b1, 12'h001, 1'b1, 12'hFFF, t0);
        wait_idle();
        for (int i = 0; i < NI; i++) begin
            d = div_of[i];
            checks++;
            if (frame_cnt[i] !== 2 || frame_log[i][0] !== 16'h3001 || frame_log[i][1] !== 16'hBFFF) begin
                failures++;
                $display("[TB] FAIL simul_frames inst%0d: got n=%0d %h %h required 2 3001 bfff",
                         i, frame_cnt[i], frame_log[i][0], frame_log[i][1]);
            end
            checks++;
            if (cs_fall[i][1] - cs_rise[i][0] !== d || cs_fall[i][1] - t0 !== 2 + 34 * d) begin
                failures++;
                $display("[TB] FAIL simul_gap inst%0d: got gap=%0d start2=%0d required %0d %0d",
                         i, cs_fall[i][1] - cs_rise[i][0], cs_fall[i][1] - t0, d, 2 + 34 * d);
            end
            checks++;
            if (ldac_cnt[i] !== 1 || ldac_fall[i][0] !== cs_rise[i][1] + d) begin
                failures++;
                $display("[TB] FAIL simul_ldac inst%0d: got n=%0d at %0d required 1 at %0d",
                         i, ldac_cnt[i], ldac_fall[i][0], cs_rise[i][1] + d);
            end
        end
    endtask

    task automatic test_overrun();
        int t0;
        int t1;
        logic [11:0] w;
        w = 12'($urandom);
        clear_logs();
        strobe(1'b1, w, 1'b0, 12'h000, t0);
        next_cycle(8);
        strobe(1'b1, 12'h111, 1'b0, 12'h000, t1);
        next_cycle(3);
        strobe(1'b1, 12'h222, 1'b0, 12'h000, t1);
        wait_idle();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ovf0_cnt[i] !== 1 || ovf1_cnt[i] !== 0) begin
                failures++;
                $display("[TB] FAIL overrun_pulse inst%0d: got ovf0=%0d ovf1=%0d required 1 0",
                         i, ovf0_cnt[i], ovf1_cnt[i]);
            end
            checks++;
            if (frame_cnt[i] !== 2 || frame_log[i][0] !== exp_frame(1'b0, w) || frame_log[i][1] !== 16'h3222) begin
                failures++;
                $display("[TB] FAIL overrun_frames inst%0d: got n=%0d %h %h required 2 %h 3222",
                         i, frame_cnt[i], frame_log[i][0], frame_log[i][1], exp_frame(1'b0, w));
            end
        end
    endtask

    task automatic test_collision();
        logic [11:0] w1;
        logic [11:0] w2;
        w1 = 12'($urandom);
        w2 = 12'($urandom);
        clear_logs();
        @(posedge clk);
        #1 dac1 = w1; dac1_dv = 1'b1;
        @(posedge clk);
        #1 dac1 = w2;
        @(posedge clk);
        #1 dac1_dv = 1'b0;
        wait_idle();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ovf1_cnt[i] !== 0 || frame_cnt[i] !== 2 || frame_log[i][0] !== exp_frame(1'b1, w1)
                || frame_log[i][1] !== exp_frame(1'b1, w2) || ldac_cnt[i] !== 2) begin
                failures++;
                $display("[TB] FAIL collision inst%0d: got ovf1=%0d n=%0d %h %h ldac=%0d required 0 2 %h %h 2",
                         i, ovf1_cnt[i], frame_cnt[i], frame_log[i][0], frame_log[i][1], ldac_cnt[i],
                         exp_frame(1'b1, w1), exp_frame(1'b1, w2));
            end
        end
    endtask

    task automatic test_chain_bound();
        int t0;
        int t1;
        logic [11:0] wa;
        logic [11:0] wb;
        logic [11:0] wa2;
        wa = 12'($urandom); wb = 12'($urandom); wa2 = 12'($urandom);
        clear_logs();
        strobe(1'b1, wa, 1'b1, wb, t0);
        next_cycle(6);
        strobe(1'b1, wa2, 1'b0, 12'h000, t1);
        wait_idle();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (frame_cnt[i] !== 3 || frame_log[i][0] !== exp_frame(1'b0, wa) || frame_log[i][1] !== exp_frame(1'b1, wb)
                || frame_log[i][2] !== exp_frame(1'b0, wa2)) begin
                failures++;
                $display("[TB] FAIL chain_frames inst%0d: got n=%0d %h %h %h required 3 %h %h %h",
                         i, frame_cnt[i], frame_log[i][0], frame_log[i][1], frame_log[i][2],
                         exp_frame(1'b0, wa), exp_frame(1'b1, wb), exp_frame(1'b0, wa2));
            end
            checks++;
            if (ldac_cnt[i] !== 2 || ldac_fall[i][0] !== cs_rise[i][1] + div_of[i] || ovf0_cnt[i] !== 0) begin
                failures++;
                $display("[TB] FAIL chain_ldac inst%0d: got n=%0d first=%0d ovf0=%0d required 2 %0d 0",
                         i, ldac_cnt[i], ldac_fall[i][0], ovf0_cnt[i], cs_rise[i][1] + div_of[i]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int t0;
        clear_logs();
        strobe(1'b1, 12'($urandom), 1'b0, 12'h000, t0);
        next_cycle(32);
        checks++;
        if ({cs_w[1], sclk_w[1]} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL reset_pre_bit7 inst1: got cs_n,sclk=%b required 01", {cs_w[1], sclk_w[1]});
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({cs_w[i], sclk_w[i], sdi_w[i], busy_w[i], ldac_w[i]} !== 5'b10001) begin
                failures++;
                $display("[TB] FAIL reset_abort inst%0d: got %b required 10001", i,
                         {cs_w[i], sclk_w[i], sdi_w[i], busy_w[i], ldac_w[i]});
            end
        end
        next_cycle(2);
        #1 rst_n = 1'b1;
        clear_logs();
        next_cycle(300);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (frame_cnt[i] !== 0 || busy_rise[i] !== -1) begin
                failures++;
                $display("[TB] FAIL reset_no_resume inst%0d: got frames=%0d busy_up=%0d required 0 -1",
                         i, frame_cnt[i], busy_rise[i]);
            end
        end
    endtask

    task automatic test_div_sweep();
        int t0;
        clear_logs();
        strobe(1'b0, 12'h000, 1'b1, 12'h5A5, t0);
        wait_idle();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (frame_log[i][0] !== 16'hB5A5 || cs_rise[i][0] - cs_fall[i][0] !== 33 * div_of[i]
                || phase_err[i] !== 0) begin
                failures++;
                $display("[TB] FAIL div_sweep inst%0d: got frame=%h cs_low=%0d perr=%0d required b5a5 %0d 0",
                         i, frame_log[i][0], cs_rise[i][0] - cs_fall[i][0], phase_err[i], 33 * div_of[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_random_frames();
        test_simultaneous();
        test_overrun();
        test_collision();
        test_chain_bound();
        test_reset_mid_shift();
        test_div_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
